// File: rtl/uart_tx_serial_if.sv
// Byte-in / serial-out bundle between the byte source (master) and the UART
// transmitter (slave).
interface uart_tx_serial_if;
  logic       enable_txd;
  logic [7:0] data;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_overrun;

  modport master (output enable_txd, data,
                  input  txd, tx_busy, tx_done, tx_overrun);
  modport slave  (input  enable_txd, data,
                  output txd, tx_busy, tx_done, tx_overrun);
endinterface

// File: rtl/uart_tx_serial.sv
// UART transmit serializer (8N1/8N2, LSB first) with a one-byte holding register.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits (PARITY_ODD selects odd).
module uart_tx_serial #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int BAUD_DIV  = CLK_FREQ / BAUD,
  parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  uart_tx_serial_if.slave bus
);

  localparam int               CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       idx, idx_next;
  logic [7:0]       shift, shift_next;
  logic [7:0]       hold, hold_next;
  logic             hold_valid, hold_valid_next;
  logic             overrun_q, overrun_next;
  logic             txd_q, txd_next;
  logic             load;
  logic [7:0]       load_byte;
  logic             bit_end, frame_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit, parity_next;
`endif

  assign bit_end   = (cnt == CNT_MAX);
  assign frame_end = (state == STOP) && bit_end && (idx == STOP_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      overrun_q  <= 1'b0;
      txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      shift      <= shift_next;
      hold       <= hold_next;
      hold_valid <= hold_valid_next;
      overrun_q  <= overrun_next;
      txd_q      <= txd_next;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    idx_next        = idx;
    shift_next      = shift;
    hold_next       = hold;
    hold_valid_next = hold_valid;
    overrun_next    = 1'b0;
    load            = 1'b0;
    load_byte       = bus.data;
    txd_next        = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next     = parity_bit;
`endif

    if (state != IDLE) cnt_next = bit_end ? '0 : cnt + 1'b1;

    unique case (state)
      START: if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end) begin
          shift_next = shift >> 1;
          if (idx == 3'd7) begin
            idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP: if (bit_end && !frame_end) idx_next = idx + 3'd1;
      default: ;
    endcase

    // The last STOP cycle both retires the frame and may accept a new byte,
    // so the held byte is promoted and the incoming one takes its place.
    if (state == IDLE) begin
      if (bus.enable_txd) load = 1'b1;
    end else if (frame_end) begin
      idx_next = '0;
      if (hold_valid) begin
        load            = 1'b1;
        load_byte       = hold;
        hold_valid_next = bus.enable_txd;
        if (bus.enable_txd) hold_next = bus.data;
      end else if (bus.enable_txd) begin
        load = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end else if (bus.enable_txd) begin
      if (!hold_valid) begin
        hold_next       = bus.data;
        hold_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end

    if (load) begin
      shift_next = load_byte;
      state_next = START;
      cnt_next   = '0;
      idx_next   = '0;
`ifdef UART_TX_PARITY_EN
      parity_next = (^load_byte) ^ (PARITY_ODD != 0);
`endif
    end

    // txd is registered from the next state so the line lines up with the state.
    unique case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = parity_next;
`endif
      default: txd_next = 1'b1;
    endcase
  end

  assign bus.txd        = txd_q;
  assign bus.tx_busy    = (state != IDLE) || hold_valid;
  assign bus.tx_done    = frame_end;
  assign bus.tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_serial.sv
// Directed bench for uart_tx_serial at BAUD_DIV=10; each scenario logs the outputs
// per cycle, then compares them against hand-built frames and pulse positions.
module tb_uart_tx_serial;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL   = NBITS * DIV;
  localparam int LOGN = 4 * FL + 20;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic tx_log   [LOGN];
  logic busy_log [LOGN];
  logic done_log [LOGN];
  logic ovr_log  [LOGN];

  int         sched_cyc  [4];
  logic [7:0] sched_byte [4];
  int         sched_n;
  int         rst_at;

  uart_tx_serial_if bus ();

  uart_tx_serial #(
    .CLK_FREQ (1000),
    .BAUD     (100),
    .STOP_BITS(1)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Line level k cycles into a frame carrying byte b.
  function automatic logic expTxd(input int k, input logic [7:0] b);
    int bitpos;
    bitpos = k / DIV;
    if (bitpos == 0) return 1'b0;
    if (bitpos <= 8) return b[bitpos-1];
`ifdef UART_TX_PARITY_EN
    if (bitpos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic doReset(input string tag);
    sys_rst = 1'b1;
    bus.enable_txd = 1'b0;
    bus.data = 8'h00;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    checkOutput({tag, "_rst_txd"}, bus.txd, 1'b1);
    checkOutput({tag, "_rst_busy"}, bus.tx_busy, 1'b0);
    checkOutput({tag, "_rst_done"}, bus.tx_done, 1'b0);
    checkOutput({tag, "_rst_ovr"}, bus.tx_overrun, 1'b0);
  endtask

  // Cycle c starts 1 time unit after an edge: outputs are logged, then inputs driven.
  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      tx_log[c]   = bus.txd;
      busy_log[c] = bus.tx_busy;
      done_log[c] = bus.tx_done;
      ovr_log[c]  = bus.tx_overrun;
      bus.enable_txd = 1'b0;
      bus.data = 8'($urandom);
      for (int k = 0; k < sched_n; k++) begin
        if (sched_cyc[k] == c) begin
          bus.enable_txd = 1'b1;
          bus.data = sched_byte[k];
        end
      end
      sys_rst = (c == rst_at);
      @(posedge sys_clk);
      #1;
    end
    bus.enable_txd = 1'b0;
    sys_rst = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input int start, input int len, input logic [7:0] b);
    for (int k = 0; k < len; k++)
      checkOutput($sformatf("%s_txd_c%0d", tag, start + k), tx_log[start + k], expTxd(k, b));
  endtask

  task automatic checkPulses(input string tag, input int which, input int n,
                             input int p0, input int p1, input int p2);
    logic obs;
    for (int c = 1; c < n; c++) begin
      obs = (which == 0) ? done_log[c] : ovr_log[c];
      checkOutput($sformatf("%s_c%0d", tag, c), obs, (c == p0) || (c == p1) || (c == p2));
    end
  endtask

  task automatic checkIdle(input string tag, input int from, input int to);
    for (int c = from; c <= to; c++) begin
      checkOutput($sformatf("%s_txd_c%0d", tag, c), tx_log[c], 1'b1);
      checkOutput($sformatf("%s_busy_c%0d", tag, c), busy_log[c], 1'b0);
    end
  endtask

  initial begin
    bus.enable_txd = 1'b0;
    bus.data = 8'h00;
    sched_n = 0;
    rst_at = -1;

    // Single byte from idle.
    doReset("s1");
    sched_cyc[0] = 0; sched_byte[0] = 8'h30; sched_n = 1; rst_at = -1;
    applyStimulus(FL + 12);
    checkOutput("s1_idle_c0", tx_log[0], 1'b1);
    checkOutput("s1_busy_c1", busy_log[1], 1'b1);
    checkOutput("s1_busy_last", busy_log[FL], 1'b1);
    checkFrame("s1", 1, FL, 8'h30);
    checkIdle("s1_after", FL + 1, FL + 11);
    checkPulses("s1_done", 0, FL + 12, FL, -1, -1);
    checkPulses("s1_ovr", 1, FL + 12, -1, -1, -1);

    // Second byte held mid-frame, sent back to back.
    doReset("s2");
    sched_cyc[0] = 0;  sched_byte[0] = 8'h31;
    sched_cyc[1] = 20; sched_byte[1] = 8'h32; sched_n = 2;
    applyStimulus(2 * FL + 12);
    checkFrame("s2a", 1, FL, 8'h31);
    checkFrame("s2b", FL + 1, FL, 8'h32);
    checkOutput("s2_busy_gap", busy_log[FL + 1], 1'b1);
    checkIdle("s2_after", 2 * FL + 1, 2 * FL + 11);
    checkPulses("s2_done", 0, 2 * FL + 12, FL, 2 * FL, -1);
    checkPulses("s2_ovr", 1, 2 * FL + 12, -1, -1, -1);

    // Third byte dropped with an overrun pulse.
    doReset("s3");
    sched_cyc[0] = 0; sched_byte[0] = 8'h33;
    sched_cyc[1] = 5; sched_byte[1] = 8'h34;
    sched_cyc[2] = 8; sched_byte[2] = 8'h35; sched_n = 3;
    applyStimulus(2 * FL + 15);
    checkFrame("s3a", 1, FL, 8'h33);
    checkFrame("s3b", FL + 1, FL, 8'h34);
    checkIdle("s3_after", 2 * FL + 1, 2 * FL + 14);
    checkPulses("s3_ovr", 1, 2 * FL + 15, 9, -1, -1);
    checkPulses("s3_done", 0, 2 * FL + 15, FL, 2 * FL, -1);

    // Reset mid-frame with a byte held, then a fresh frame.
    doReset("s4");
    sched_cyc[0] = 0;  sched_byte[0] = 8'h30;
    sched_cyc[1] = 10; sched_byte[1] = 8'h39;
    sched_cyc[2] = 50; sched_byte[2] = 8'h36; sched_n = 3;
    rst_at = 45;
    applyStimulus(51 + FL + 12);
    rst_at = -1;
    checkFrame("s4pre", 1, 45, 8'h30);
    checkIdle("s4_rst", 46, 50);
    checkFrame("s4", 51, FL, 8'h36);
    checkIdle("s4_after", 51 + FL, 51 + FL + 11);
    checkPulses("s4_done", 0, 51 + FL + 12, 50 + FL, -1, -1);
    checkPulses("s4_ovr", 1, 51 + FL + 12, -1, -1, -1);

    // Strobe in the last stop cycle while a byte is held.
    doReset("s5");
    sched_cyc[0] = 0;  sched_byte[0] = 8'h3A;
    sched_cyc[1] = 20; sched_byte[1] = 8'h37;
    sched_cyc[2] = FL; sched_byte[2] = 8'h38; sched_n = 3;
    applyStimulus(3 * FL + 12);
    checkFrame("s5a", 1, FL, 8'h3A);
    checkFrame("s5b", FL + 1, FL, 8'h37);
    checkFrame("s5c", 2 * FL + 1, FL, 8'h38);
    checkIdle("s5_after", 3 * FL + 1, 3 * FL + 11);
    checkPulses("s5_done", 0, 3 * FL + 12, FL, 2 * FL, 3 * FL);
    checkPulses("s5_ovr", 1, 3 * FL + 12, -1, -1, -1);

    // Strobe in the last stop cycle with nothing held.
    doReset("s6");
    sched_cyc[0] = 0;  sched_byte[0] = 8'h3B;
    sched_cyc[1] = FL; sched_byte[1] = 8'hC5; sched_n = 2;
    applyStimulus(2 * FL + 12);
    checkFrame("s6a", 1, FL, 8'h3B);
    checkFrame("s6b", FL + 1, FL, 8'hC5);
    checkIdle("s6_after", 2 * FL + 1, 2 * FL + 11);
    checkPulses("s6_done", 0, 2 * FL + 12, FL, 2 * FL, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
